// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_unit_pkg;
  localparam int IP_WIDTH   = 4;
  localparam int LINE_WIDTH = 32;
  localparam int NUM_LINES  = 4;

  // Line value that terminates a program.
  localparam logic [LINE_WIDTH-1:0] END_MARKER = 32'hffffffff;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_FETCH = 2'd1,
    FS_HALT  = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/fetch_unit_ip_counter.sv
// Instruction pointer register: load has priority over increment, otherwise hold.
module ip_counter
  import fetch_unit_pkg::*;
#(
  parameter int IW = IP_WIDTH
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          load,
  input  logic [IW-1:0] load_val,
  input  logic          inc,
  output logic [IW-1:0] pc
);

  // pc update: load a new pointer, step to the next line, or hold
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)     pc <= '0;
    else if (load) pc <= load_val;
    else if (inc)  pc <= pc + IW'(1);
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: drives the line memory read port, captures one
// instruction per cycle and stops at the end marker or on a bad jump target.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int            IW       = IP_WIDTH,
  parameter int            LW       = LINE_WIDTH,
  parameter int            NLINES   = NUM_LINES,
  parameter logic [IW-1:0] START_IP = '0
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          start,
  input  logic          stall,
  input  logic          jump_valid,
  input  logic [IW-1:0] jump_target,
  output logic          mem_en,
  output logic [IW-1:0] mem_ip,
  input  logic [LW-1:0] mem_line,
  output logic          instr_valid,
  output logic [LW-1:0] instr,
  output logic [IW-1:0] instr_ip,
  output logic          halted,
  output logic          fault
);

  localparam logic [LW-1:0] MARKER = LW'(END_MARKER);

  fetch_state_t  state, state_nxt;
  logic [IW-1:0] pc;
  logic          pc_load, pc_inc;
  logic [IW-1:0] pc_load_val;
  // one-hot-ish event flags for the registered side
  logic          ev_start, ev_jump, ev_fault, ev_end, ev_cap;
  logic          tgt_ok;

  assign tgt_ok = int'(jump_target) <= NLINES;
  assign mem_ip = pc;
  assign mem_en = (state == FS_FETCH) && !stall;

  ip_counter #(.IW(IW)) u_ipc (
    .clk      (clk),
    .nrst     (nrst),
    .load     (pc_load),
    .load_val (pc_load_val),
    .inc      (pc_inc),
    .pc       (pc)
  );

  // Decode this cycle's event in priority order: jump, stall, marker, capture
  always_comb begin
    state_nxt   = state;
    pc_load     = 1'b0;
    pc_load_val = START_IP;
    pc_inc      = 1'b0;
    ev_start    = 1'b0;
    ev_jump     = 1'b0;
    ev_fault    = 1'b0;
    ev_end      = 1'b0;
    ev_cap      = 1'b0;
    case (state)
      FS_IDLE, FS_HALT: begin
        if (start) begin
          ev_start  = 1'b1;
          pc_load   = 1'b1;
          state_nxt = FS_FETCH;
        end
      end
      FS_FETCH: begin
        if (jump_valid) begin
          if (tgt_ok) begin
            ev_jump     = 1'b1;
            pc_load     = 1'b1;
            pc_load_val = jump_target;
          end else begin
            ev_fault  = 1'b1;
            state_nxt = FS_HALT;
          end
        end else if (!stall) begin
          if (mem_line == MARKER) begin
            ev_end    = 1'b1;
            state_nxt = FS_HALT;
          end else begin
            ev_cap = 1'b1;
            pc_inc = 1'b1;
          end
        end
      end
      default: state_nxt = FS_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= FS_IDLE;
    else       state <= state_nxt;
  end

  // Capture register and halt/fault status; stall leaves everything untouched
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      instr       <= '0;
      instr_ip    <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      fault       <= 1'b0;
    end else begin
      if (ev_start) begin
        halted <= 1'b0;
        fault  <= 1'b0;
      end
      if (ev_jump || ev_fault || ev_end) instr_valid <= 1'b0;
      if (ev_fault) fault <= 1'b1;
      if (ev_fault || ev_end) halted <= 1'b1;
      if (ev_cap) begin
        instr       <= mem_line;
        instr_ip    <= pc;
        instr_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random start/stall/jump traffic,
// all checked against a program-level reference model.
module tb_fetch_unit;
  localparam int IW = 4;
  localparam int LW = 32;
  localparam int NL = 4;

  logic          clk = 1'b0;
  logic          nrst;
  logic          start, stall, jump_valid;
  logic [IW-1:0] jump_target;
  logic          mem_en;
  logic [IW-1:0] mem_ip;
  logic [LW-1:0] mem_line;
  logic          instr_valid;
  logic [LW-1:0] instr;
  logic [IW-1:0] instr_ip;
  logic          halted, fault;

  logic [LW-1:0] prog [NL+1];

  int nvec = 0;
  int nmis = 0;

  // reference model state
  bit            m_run, m_halted, m_fault, m_valid;
  int            m_pc, m_ip;
  logic [LW-1:0] m_instr;

  always #5 clk = ~clk;

  // line memory: combinational read, marker at index NL
  assign mem_line = (int'(mem_ip) <= NL) ? prog[mem_ip] : '0;

  fetch_unit #(.IW(IW), .LW(LW), .NLINES(NL), .START_IP('0)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .start       (start),
    .stall       (stall),
    .jump_valid  (jump_valid),
    .jump_target (jump_target),
    .mem_en      (mem_en),
    .mem_ip      (mem_ip),
    .mem_line    (mem_line),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ip    (instr_ip),
    .halted      (halted),
    .fault       (fault)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_halted = 0; m_fault = 0; m_valid = 0;
    m_pc = 0; m_ip = 0; m_instr = '0;
  endtask

  // one clock of program-level behaviour
  task automatic model_step(input bit s, input bit st, input bit jv, input int jt);
    if (!m_run) begin
      if (s) begin
        m_pc = 0; m_run = 1; m_halted = 0; m_fault = 0;
      end
    end else if (jv) begin
      m_valid = 0;
      if (jt <= NL) m_pc = jt;
      else begin
        m_run = 0; m_halted = 1; m_fault = 1;
      end
    end else if (!st) begin
      if (prog[m_pc] == 32'hffffffff) begin
        m_run = 0; m_halted = 1; m_valid = 0;
      end else begin
        m_instr = prog[m_pc]; m_ip = m_pc; m_valid = 1; m_pc++;
      end
    end
  endtask

  task automatic check_regs();
    chk("instr_valid", instr_valid, m_valid);
    chk("instr", instr, m_instr);
    chk("instr_ip", instr_ip, m_ip);
    chk("halted", halted, m_halted);
    chk("fault", fault, m_fault);
    chk("pc", mem_ip, m_pc);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(input bit s, input bit st, input bit jv, input int jt);
    start = s; stall = st; jump_valid = jv; jump_target = IW'(jt);
    #1;
    chk("mem_en", mem_en, m_run && !st);
    chk("mem_ip", mem_ip, m_pc);
    model_step(s, st, jv, jt);
    @(posedge clk); #1;
    check_regs();
    @(negedge clk);
  endtask

  initial begin
    prog[0] = 32'h03002336; prog[1] = 32'h02000011;
    prog[2] = 32'hf0000000; prog[3] = 32'h00000000;
    prog[4] = 32'hffffffff;
    nrst = 1'b0; start = 0; stall = 0; jump_valid = 0; jump_target = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_instr", instr, 32'h0);
    @(negedge clk);
    nrst = 1'b1;

    // 1: straight-line run to the marker
    cycle(1, 0, 0, 0);
    for (int k = 0; k < NL; k++) begin
      cycle(0, 0, 0, 0);
      chk("t1_instr", instr, prog[k]);
      chk("t1_ip", instr_ip, IW'(k));
    end
    cycle(0, 0, 0, 0);
    chk("t1_halted", halted, 1'b1);
    chk("t1_valid", instr_valid, 1'b0);

    // 2: stall while 02000011 is held
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cycle(0, 1, 0, 0);
      chk("t2_hold", instr, 32'h02000011);
    end
    cycle(0, 0, 0, 0);
    chk("t2_resume", instr, 32'hf0000000);

    // 3: jump back to 0 from instr_ip=2
    cycle(0, 0, 1, 0);
    chk("t3_bubble", instr_valid, 1'b0);
    cycle(0, 0, 0, 0);
    chk("t3_target", instr, 32'h03002336);
    chk("t3_target_ip", instr_ip, 4'd0);

    // 4: out-of-range jump faults; start recovers
    cycle(0, 0, 1, 7);
    chk("t4_fault", fault, 1'b1);
    cycle(1, 0, 0, 0);
    chk("t4_clear", fault, 1'b0);
    cycle(0, 0, 0, 0);
    chk("t4_refetch", instr_ip, 4'd0);

    // 5: jump beats stall, then an asynchronous reset mid-fetch
    cycle(0, 1, 1, 1);
    cycle(0, 0, 0, 0);
    chk("t5_jump_ip", instr_ip, 4'd1);
    #3 nrst = 1'b0;
    #1;
    model_reset();
    check_regs();
    chk("t5_rst_mem_en", mem_en, 1'b0);
    @(negedge clk);
    nrst = 1'b1;

    // random traffic
    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 9) == 0, int'($urandom_range(0, 9)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
